// File: rtl/mul_hilo_unit_pkg.sv
// rtl/mul_hilo_unit_pkg.sv - shared op/state encodings for the HI/LO multiply unit
package mul_hilo_unit_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      MUL_MULT  = 3'd0,
      MUL_MULTU = 3'd1,
      MUL_MADD  = 3'd2,
      MUL_MSUB  = 3'd3,
      MUL_MTHI  = 3'd4,
      MUL_MTLO  = 3'd5
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } mul_state_e;

   // Ops that occupy the iterative multiplier (MULT..MSUB).
   function automatic logic is_mul_op(input logic [2:0] op);
      return (op <= 3'd3);
   endfunction

endpackage

// File: rtl/mul_hilo_unit_core.sv
// rtl/mul_hilo_unit_core.sv - unsigned shift-add multiplier, one multiplier bit per cycle
module mul_hilo_unit_core #(
   parameter int WIDTH = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [WIDTH-1:0]   i_mcand,
   input  logic [WIDTH-1:0]   i_mplier,
   output logic [2*WIDTH-1:0] o_product,
   output logic               o_last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_mplier;
   logic [2*WIDTH-1:0] r_product;
   logic [CW-1:0]      r_cnt;
   logic               r_run;
   logic [2*WIDTH-1:0] w_addend;

   assign w_addend = r_mcand[0] ? (r_mplier << r_cnt) : '0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_product <= '0;
         r_cnt     <= '0;
         r_run     <= 1'b0;
      end else if (i_load) begin
         r_mcand   <= i_mcand;
         r_mplier  <= {{WIDTH{1'b0}}, i_mplier};
         r_product <= '0;
         r_cnt     <= '0;
         r_run     <= 1'b1;
      end else if (r_run) begin
         r_product <= r_product + w_addend;
         r_mcand   <= r_mcand >> 1;
         r_cnt     <= r_cnt + 1'b1;
         if (r_cnt == LAST_CNT) begin
            r_run <= 1'b0;
         end
      end
   end

   // High on the edge that folds in the final multiplier bit.
   assign o_last    = r_run && (r_cnt == LAST_CNT);
   assign o_product = r_product;

endmodule

// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - iterative mult/madd/msub unit holding architectural HI/LO
module mul_hilo_unit
   import mul_hilo_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_stall,
   output logic             o_done
);

   mul_state_e r_state;
   mul_state_e w_next_state;

   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic [2:0]         r_op;
   logic               r_signfix;

   logic               w_load;
   logic               w_write;
   logic               w_last;
   logic               w_signed;
   logic               w_signfix;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [2*WIDTH-1:0] w_product;
   logic [2*WIDTH-1:0] w_p;
   logic [2*WIDTH-1:0] w_hilo;
   logic [2*WIDTH-1:0] w_new_hilo;

   // Magnitudes of 0x80..0 stay 0x80..0, read as unsigned by the core.
   assign w_signed  = (i_op != MUL_MULTU);
   assign w_mag_a   = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_mag_b   = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
   assign w_signfix = w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);

   mul_hilo_unit_core #(.WIDTH(WIDTH)) u_core (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_load),
      .i_mcand   (w_mag_a),
      .i_mplier  (w_mag_b),
      .o_product (w_product),
      .o_last    (w_last)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (i_start && is_mul_op(i_op)) w_next_state = ST_RUN;
         ST_RUN:    if (w_last) w_next_state = ST_FINISH;
         ST_FINISH: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load  = 1'b0;
      w_write = 1'b0;
      case (r_state)
         ST_IDLE:   w_load  = i_start && is_mul_op(i_op);
         ST_FINISH: w_write = 1'b1;
         default:   ;
      endcase
   end

   assign w_hilo = {r_hi, r_lo};
   assign w_p    = r_signfix ? -w_product : w_product;

   always_comb begin
      w_new_hilo = w_p;
      case (r_op)
         MUL_MADD: w_new_hilo = w_hilo + w_p;
         MUL_MSUB: w_new_hilo = w_hilo - w_p;
         default:  w_new_hilo = w_p;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_op      <= '0;
         r_signfix <= 1'b0;
      end else begin
         r_done <= w_write;
         if (w_load) begin
            r_op      <= i_op;
            r_signfix <= w_signfix;
            r_busy    <= 1'b1;
         end else if (w_write) begin
            r_busy <= 1'b0;
         end
         if (w_write) begin
            {r_hi, r_lo} <= w_new_hilo;
         end else if (r_state == ST_IDLE && i_start) begin
            if (i_op == MUL_MTHI) r_hi <= i_a;
            if (i_op == MUL_MTLO) r_lo <= i_a;
         end
      end
   end

   assign o_hi    = r_hi;
   assign o_lo    = r_lo;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_stall = r_busy | w_load;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - scoreboard bench for mul_hilo_unit
module tb_mul_hilo_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [2:0]  i_op = 3'd0;
   logic [31:0] i_a = '0;
   logic [31:0] i_b = '0;
   logic [31:0] o_hi, o_lo;
   logic        o_busy, o_stall, o_done;

   int total = 0;
   int bad = 0;
   logic [63:0] sb[$];
   logic [63:0] m_hilo = '0;
   logic        s_stall;

   mul_hilo_unit #(.WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (i_start),
      .i_op    (i_op),
      .i_a     (i_a),
      .i_b     (i_b),
      .o_hi    (o_hi),
      .o_lo    (o_lo),
      .o_busy  (o_busy),
      .o_stall (o_stall),
      .o_done  (o_done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hilo);
      logic signed [63:0] sa, sb_;
      logic [63:0] p;
      sa  = {{32{a[31]}}, a};
      sb_ = {{32{b[31]}}, b};
      if (op == 3'd1) p = {32'd0, a} * {32'd0, b};
      else            p = sa * sb_;
      case (op)
         3'd2:    return hilo + p;
         3'd3:    return hilo - p;
         default: return p;
      endcase
   endfunction

   // Caller is at a negedge; returns 1ns after the accepting posedge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      #1 s_stall = o_stall;
      if (op <= 3'd3) begin
         m_hilo = model(op, a, b, m_hilo);
         sb.push_back(m_hilo);
      end else if (op == 3'd4) m_hilo[63:32] = a;
      else if (op == 3'd5) m_hilo[31:0] = a;
      @(posedge clk);
      #1 i_start = 1'b0;
   endtask

   task automatic wait_done(output int busy_cycles, output bit timeout);
      busy_cycles = 0;
      timeout = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_done) begin
            timeout = 1'b0;
            break;
         end
         if (o_busy) busy_cycles++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (o_hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", o_hi); end
      total++; if (o_lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", o_lo); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", o_stall); end
      rst = 1'b0;
      m_hilo = '0;
   endtask

   task automatic test_mul(input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
      int bc; bit to; logic [63:0] exp;
      @(negedge clk);
      issue(op, a, b);
      total++; if (s_stall !== 1'b1) begin bad++; $display("FAIL %s_stall got=%b want=1", name, s_stall); end
      wait_done(bc, to);
      total++; if (to) begin bad++; $display("FAIL %s_timeout no done within 100 cycles", name); end
      total++; if (bc != 33) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=33", name, bc); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done got=%b want=0", name, o_busy); end
      if (sb.size() == 0) begin
         total++; bad++; $display("FAIL %s_scoreboard empty queue", name);
      end else begin
         exp = sb.pop_front();
         total++;
         if ({o_hi, o_lo} !== exp) begin
            bad++; $display("FAIL %s_hilo got=%h_%h want=%h_%h", name, o_hi, o_lo, exp[63:32], exp[31:0]);
         end
      end
      @(negedge clk);
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL %s_done_width got=%b want=0", name, o_done); end
   endtask

   task automatic test_move_and_nop;
      @(negedge clk);
      issue(3'd4, 32'd0, 32'd0);
      total++; if (s_stall !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%b want=0", s_stall); end
      @(negedge clk);
      issue(3'd5, 32'd5, 32'd0);
      @(negedge clk);
      total++; if (o_hi !== m_hilo[63:32]) begin bad++; $display("FAIL mthi_hi got=%h want=%h", o_hi, m_hilo[63:32]); end
      total++; if (o_lo !== m_hilo[31:0]) begin bad++; $display("FAIL mtlo_lo got=%h want=%h", o_lo, m_hilo[31:0]); end
      total++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         bad++; $display("FAIL move_flags busy=%b done=%b want=0,0", o_busy, o_done);
      end
      issue(3'd6, 32'hDEAD_BEEF, 32'h1);
      total++; if (s_stall !== 1'b0) begin bad++; $display("FAIL nop_stall got=%b want=0", s_stall); end
      @(negedge clk);
      total++; if ({o_hi, o_lo} !== m_hilo || o_busy !== 1'b0 || o_done !== 1'b0) begin
         bad++; $display("FAIL nop_effect hilo=%h_%h busy=%b done=%b want=%h", o_hi, o_lo, o_busy, o_done, m_hilo);
      end
   endtask

   task automatic test_reset_abort;
      bit seen; logic [63:0] dropped;
      @(negedge clk);
      issue(3'd0, 32'd7, 32'd9);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", o_busy); end
      total++; if ({o_hi, o_lo} !== 64'd0) begin bad++; $display("FAIL abort_hilo got=%h_%h want=0", o_hi, o_lo); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_hilo = '0;
      if (sb.size() > 0) dropped = sb.pop_front();
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_done) seen = 1'b1;
      end
      total++; if (seen) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
   endtask

   task automatic test_ignore_busy;
      int bc; bit to; logic [63:0] exp;
      @(negedge clk);
      issue(3'd1, 32'h0001_0001, 32'h0000_00FF);
      repeat (5) @(negedge clk);
      i_start = 1'b1; i_op = 3'd5; i_a = 32'h1234;
      #1;
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL busy_mtlo_stall got=%b want=1", o_stall); end
      @(posedge clk);
      #1 i_start = 1'b0;
      wait_done(bc, to);
      total++; if (to) begin bad++; $display("FAIL ignore_timeout no done"); end
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
      total++; if ({o_hi, o_lo} !== exp) begin
         bad++; $display("FAIL ignore_hilo got=%h_%h want=%h", o_hi, o_lo, exp);
      end
   endtask

   task automatic test_back_to_back;
      int bc; bit to; logic [63:0] exp;
      @(negedge clk);
      issue(3'd0, 32'hFFFF_FFF9, 32'd11);
      wait_done(bc, to);
      total++; if (to) begin bad++; $display("FAIL b2b_first_timeout no done"); end
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
      total++; if ({o_hi, o_lo} !== exp) begin bad++; $display("FAIL b2b_first got=%h_%h want=%h", o_hi, o_lo, exp); end
      issue(3'd2, 32'h1234_5678, 32'h9ABC_DEF0);
      total++; if (s_stall !== 1'b1) begin bad++; $display("FAIL b2b_accept_stall got=%b want=1", s_stall); end
      wait_done(bc, to);
      total++; if (to || bc != 33) begin bad++; $display("FAIL b2b_second_busy got=%0d timeout=%b want=33", bc, to); end
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
      total++; if ({o_hi, o_lo} !== exp) begin bad++; $display("FAIL b2b_second got=%h_%h want=%h", o_hi, o_lo, exp); end
   endtask

   initial begin
      test_reset();
      test_mul("mult_3_m4", 3'd0, 32'd3, 32'hFFFF_FFFC);
      test_mul("multu_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      test_mul("mult_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      test_move_and_nop();
      test_mul("madd_2_3", 3'd2, 32'd2, 32'd3);
      test_mul("msub_4_3", 3'd3, 32'd4, 32'd3);
      test_mul("mult_min_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
      test_mul("mult_min_1", 3'd0, 32'h8000_0000, 32'd1);
      test_reset_abort();
      test_mul("mult_7_9", 3'd0, 32'd7, 32'd9);
      test_ignore_busy();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
